piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 9 +
 rtl/piso_hold_reg.sv | 40 ++++
 rtl/piso_tx.sv | 96 +++++++++
 tb/tb_piso_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in / serial-out transmitter.
package piso_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding register with a full flag; load wins over clear.
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             full_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             full_q, full_d;

  always_comb begin
    q_d    = q_q;
    full_d = full_q;
    if (clr_i) full_d = 1'b0;
    if (load_i) begin
      q_d    = d_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      full_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      full_q <= full_d;
    end
  end

  assign q_o    = q_q;
  assign full_o = full_q;
endmodule

// File: rtl/piso_tx.sv
// Serializer: shifter + one-word holding register, back-to-back frames
// without gaps. First bit appears the cycle after the word is loaded.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             last_bit,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             serial_q, frame_q;

  logic             hold_full;
  logic [WIDTH-1:0] hold_word;

  logic             accept, at_last, load_sh, hold_to_sh, load_hold;
  logic [WIDTH-1:0] ld_word, ld_rest, sh_next;
  logic             ld_bit, cur_bit;

  assign in_ready   = ~hold_full;
  assign accept     = in_valid & in_ready;
  assign at_last    = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign hold_to_sh = at_last & hold_full;
  // Direct-to-shifter only when nothing is queued ahead of the new word.
  assign load_sh    = accept & ((state_q == IDLE) | (at_last & ~hold_full));
  assign load_hold  = accept & ~load_sh;

  always_comb begin
    ld_word = hold_to_sh ? hold_word : parallel_in;
    if (LSB_FIRST) begin
      ld_bit  = ld_word[0];
      ld_rest = ld_word >> 1;
      cur_bit = sh_q[0];
      sh_next = sh_q >> 1;
    end else begin
      ld_bit  = ld_word[WIDTH-1];
      ld_rest = ld_word << 1;
      cur_bit = sh_q[WIDTH-1];
      sh_next = sh_q << 1;
    end
  end

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_hold),
    .clr_i  (hold_to_sh),
    .d_i    (parallel_in),
    .q_o    (hold_word),
    .full_o (hold_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
    end else if (load_sh || hold_to_sh) begin
      state_q  <= SHIFT;
      sh_q     <= ld_rest;
      cnt_q    <= '0;
      serial_q <= ld_bit;
      frame_q  <= 1'b1;
    end else if (at_last) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      sh_q     <= sh_next;
      cnt_q    <= cnt_q + CW'(1);
      serial_q <= cur_bit;
    end
  end

  assign serial_out = serial_q;
  assign frame      = frame_q;
  assign last_bit   = frame_q && (cnt_q == CW'(WIDTH - 1));
  assign busy       = (state_q == SHIFT) | hold_full;
endmodule

// File: tb/tb_piso_tx.sv
// Randomized and directed checks of piso_tx against a word-queue model.
module tb_piso_tx;
  logic       clk, rst;
  logic [3:0] din;
  logic       vld, rdy, so, fr, lb, bsy;
  logic [7:0] dinb;
  logic       vldb, rdyb, sob, frb, lbb, bsyb;

  int total = 0, bad = 0;

  // model: words owed on the wire, oldest first; pos = bit index on the wire now
  logic [3:0] wq[$];
  int         pos = 0;
  logic [3:0] sendq[$];
  logic [31:0] cap;
  int         ncap;

  piso_tx u_dut (
    .clk(clk), .rst(rst), .parallel_in(din), .in_valid(vld), .in_ready(rdy),
    .serial_out(so), .frame(fr), .last_bit(lb), .busy(bsy)
  );

  piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .parallel_in(dinb), .in_valid(vldb), .in_ready(rdyb),
    .serial_out(sob), .frame(frb), .last_bit(lbb), .busy(bsyb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(output bit acc);
    logic [3:0] w;
    logic       ef, eb;
    acc = vld && (wq.size() < 2);
    @(posedge clk);
    if (rst) begin
      wq.delete();
      pos = 0;
    end else begin
      if (wq.size() != 0) begin
        pos++;
        if (pos == 4) begin
          void'(wq.pop_front());
          pos = 0;
        end
      end
      if (acc) wq.push_back(din);
    end
    #1;
    ef = (wq.size() != 0);
    w  = ef ? wq[0] : 4'h0;
    eb = ef ? w[3-pos] : 1'b0;
    chk("serial", so, eb);
    chk("frame", fr, ef);
    chk("last_bit", lb, ef && (pos == 3));
    chk("busy", bsy, ef);
    chk("in_ready", rdy, wq.size() < 2);
    if (fr) begin
      cap = {cap[30:0], so};
      ncap++;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    vld = 1'b0;
    repeat (n) tick(a);
  endtask

  task automatic drain(input int maxc);
    bit a;
    int g = 0;
    while (sendq.size() != 0 && g < maxc) begin
      vld = 1'b1;
      din = sendq[0];
      tick(a);
      if (a) void'(sendq.pop_front());
      g++;
    end
    vld = 1'b0;
    din = 4'h0;
    if (sendq.size() != 0) begin
      chk("send_timeout", sendq.size(), 0);
      sendq.delete();
    end
  endtask

  // 8-bit LSB-first instance: nw words, second one offered right after the first
  task automatic runb(input logic [7:0] w0, input logic [7:0] w1, input int nw);
    bit a;
    logic [15:0] s;
    logic ef;
    s = {w1, w0};
    for (int t = 0; t < nw * 8 + 2; t++) begin
      vldb = (t < nw);
      dinb = (t == 0) ? w0 : w1;
      tick(a);
      ef = (t + 1 <= nw * 8);
      chk("b_frame", frb, ef);
      chk("b_serial", sob, ef ? s[t] : 1'b0);
      chk("b_last", lbb, (t + 1 == 8) || (nw == 2 && t + 1 == 16));
    end
    vldb = 1'b0;
  endtask

  initial begin
    bit a;
    int g;
    rst = 1'b1; vld = 1'b0; din = 4'h0; vldb = 1'b0; dinb = 8'h0;
    cap = 0; ncap = 0;
    tick(a);
    tick(a);
    chk("rst_b_ready", rdyb, 1'b1);
    chk("rst_b_frame", frb, 1'b0);
    rst = 1'b0;
    idle(2);

    // single word 1011
    cap = 0; ncap = 0;
    sendq = '{4'hB};
    drain(20);
    idle(6);
    chk("w1011_bits", cap[3:0], 4'hB);
    chk("w1011_len", ncap, 4);

    // back-to-back A,5 with valid held
    cap = 0; ncap = 0;
    sendq = '{4'hA, 4'h5};
    drain(20);
    idle(10);
    chk("a5_bits", cap[7:0], 8'hA5);
    chk("a5_len", ncap, 8);

    // third word waits for the holding register
    cap = 0; ncap = 0;
    sendq = '{4'hA, 4'h5, 4'hF};
    drain(30);
    idle(14);
    chk("a5f_bits", cap[11:0], 12'hA5F);
    chk("a5f_len", ncap, 12);

    // reset during bit 2 of C with 3 held
    cap = 0; ncap = 0;
    sendq = '{4'hC, 4'h3};
    drain(20);
    rst = 1'b1;
    tick(a);
    rst = 1'b0;
    chk("rst_mid_frame", fr, 1'b0);
    chk("rst_mid_ready", rdy, 1'b1);
    idle(8);
    chk("rst_mid_bits", cap[1:0], 2'b11);
    chk("rst_mid_len", ncap, 2);

    // 9 offered exactly on the last-bit cycle of 6
    cap = 0; ncap = 0;
    sendq = '{4'h6};
    drain(20);
    g = 0;
    while (pos != 3 && g < 10) begin
      tick(a);
      g++;
    end
    sendq = '{4'h9};
    drain(20);
    idle(10);
    chk("69_bits", cap[7:0], 8'h69);
    chk("69_len", ncap, 8);

    // wide LSB-first instance
    runb(8'h01, 8'h00, 1);
    runb(8'hA5, 8'h3C, 2);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      din = 4'($urandom);
      rst = ($urandom_range(0, 60) == 0);
      tick(a);
    end
    rst = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
